// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the gpio_bank_wb Wishbone GPIO bank: register offsets,
// bus FSM states and the byte-lane merge helper.
package gpio_bank_pkg;

    localparam logic [7:0] GPIO_IN_OFS       = 8'h00;
    localparam logic [7:0] GPIO_OUT_OFS      = 8'h04;
    localparam logic [7:0] GPIO_OEB_OFS      = 8'h08;
    localparam logic [7:0] GPIO_PU_OFS       = 8'h0C;
    localparam logic [7:0] GPIO_PD_OFS       = 8'h10;
    localparam logic [7:0] GPIO_RISE_EN_OFS  = 8'h14;
    localparam logic [7:0] GPIO_FALL_EN_OFS  = 8'h18;
    localparam logic [7:0] GPIO_IRQ_STAT_OFS = 8'h1C;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = sel[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser. With GPIO_BANK_IRQ_EN defined, a third stage is added
// and masked rise/fall events are produced per pin.
module gpio_sync_edge #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] sync_o
`ifdef GPIO_BANK_IRQ_EN
    ,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    output logic [WIDTH-1:0] event_o
`endif
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = pad_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign sync_o = s2_q;

`ifdef GPIO_BANK_IRQ_EN
    logic [WIDTH-1:0] s3_q, s3_d;

    always_comb begin
        s3_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_q <= '0;
        end else begin
            s3_q <= s3_d;
        end
    end

    assign event_o = (s2_q & ~s3_q & rise_en_i) | (~s2_q & s3_q & fall_en_i);
`endif

endmodule

// File: rtl/gpio_bank_wb.sv
// Wishbone-slave GPIO bank with per-pin out/oeb/pull controls. Edge interrupts
// are present only when GPIO_BANK_IRQ_EN is defined.
module gpio_bank_wb
    import gpio_bank_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h2100_0000,
    parameter int          N_GPIO   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [N_GPIO-1:0] gpio_in_pad,
    output logic [N_GPIO-1:0] gpio,
    output logic [N_GPIO-1:0] gpio_oeb,
    output logic [N_GPIO-1:0] gpio_pu,
    output logic [N_GPIO-1:0] gpio_pd,
    output logic              irq
);

    // Byte-masked update of an N_GPIO-wide register; lanes above N_GPIO drop out.
    function automatic logic [N_GPIO-1:0] merge_n(input logic [N_GPIO-1:0] old_v,
                                                  input logic [31:0]       new_v,
                                                  input logic [3:0]        sel);
        logic [31:0] o32;
        logic [31:0] m;
        o32 = '0;
        o32[N_GPIO-1:0] = old_v;
        m = byte_merge(o32, new_v, sel);
        return m[N_GPIO-1:0];
    endfunction

    bus_state_e        state_q, state_d;
    logic [31:0]       dat_q, dat_d;
    logic [N_GPIO-1:0] out_q, out_d;
    logic [N_GPIO-1:0] oeb_q, oeb_d;
    logic [N_GPIO-1:0] pu_q, pu_d;
    logic [N_GPIO-1:0] pd_q, pd_d;
    logic [N_GPIO-1:0] sync_in;

    logic       page_hit;
    logic       valid;
    logic       wr;
    logic [7:0] ofs;
    logic [31:0] rdata;

`ifdef GPIO_BANK_IRQ_EN
    logic [N_GPIO-1:0] rise_q, rise_d;
    logic [N_GPIO-1:0] fall_q, fall_d;
    logic [N_GPIO-1:0] stat_q, stat_d;
    logic [N_GPIO-1:0] stat_clr;
    logic [N_GPIO-1:0] edge_evt;

    gpio_sync_edge #(.WIDTH(N_GPIO)) u_sync (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .pad_i     (gpio_in_pad),
        .sync_o    (sync_in),
        .rise_en_i (rise_q),
        .fall_en_i (fall_q),
        .event_o   (edge_evt)
    );
`else
    gpio_sync_edge #(.WIDTH(N_GPIO)) u_sync (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .pad_i  (gpio_in_pad),
        .sync_o (sync_in)
    );
`endif

    assign wb_ack_o = (state_q == BUS_ACK);
    assign page_hit = (wb_adr_i[31:8] == BASE_ADR[31:8]);
    assign valid    = wb_cyc_i & wb_stb_i & ~wb_ack_o & page_hit;
    assign wr       = valid & wb_we_i;
    assign ofs      = wb_adr_i[7:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (valid) state_d = BUS_ACK;
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        oeb_d = oeb_q;
        pu_d  = pu_q;
        pd_d  = pd_q;
        if (wr) begin
            case (ofs)
                GPIO_OUT_OFS: out_d = merge_n(out_q, wb_dat_i, wb_sel_i);
                GPIO_OEB_OFS: oeb_d = merge_n(oeb_q, wb_dat_i, wb_sel_i);
                GPIO_PU_OFS:  pu_d  = merge_n(pu_q,  wb_dat_i, wb_sel_i);
                GPIO_PD_OFS:  pd_d  = merge_n(pd_q,  wb_dat_i, wb_sel_i);
                default: ;
            endcase
        end
    end

`ifdef GPIO_BANK_IRQ_EN
    always_comb begin
        rise_d   = rise_q;
        fall_d   = fall_q;
        stat_clr = '0;
        if (wr) begin
            case (ofs)
                GPIO_RISE_EN_OFS:  rise_d   = merge_n(rise_q, wb_dat_i, wb_sel_i);
                GPIO_FALL_EN_OFS:  fall_d   = merge_n(fall_q, wb_dat_i, wb_sel_i);
                GPIO_IRQ_STAT_OFS: stat_clr = merge_n('0, wb_dat_i, wb_sel_i);
                default: ;
            endcase
        end
        // A new event outranks a simultaneous W1C of the same bit.
        stat_d = (stat_q & ~stat_clr) | edge_evt;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rise_q <= '0;
            fall_q <= '0;
            stat_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            stat_q <= stat_d;
        end
    end

    assign irq = |stat_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (ofs)
            GPIO_IN_OFS:       rdata[N_GPIO-1:0] = sync_in;
            GPIO_OUT_OFS:      rdata[N_GPIO-1:0] = out_q;
            GPIO_OEB_OFS:      rdata[N_GPIO-1:0] = oeb_q;
            GPIO_PU_OFS:       rdata[N_GPIO-1:0] = pu_q;
            GPIO_PD_OFS:       rdata[N_GPIO-1:0] = pd_q;
`ifdef GPIO_BANK_IRQ_EN
            GPIO_RISE_EN_OFS:  rdata[N_GPIO-1:0] = rise_q;
            GPIO_FALL_EN_OFS:  rdata[N_GPIO-1:0] = fall_q;
            GPIO_IRQ_STAT_OFS: rdata[N_GPIO-1:0] = stat_q;
`endif
            default: ;
        endcase
        dat_d = (valid & ~wb_we_i) ? rdata : dat_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= BUS_IDLE;
            dat_q   <= '0;
            out_q   <= '0;
            oeb_q   <= '1;
            pu_q    <= '0;
            pd_q    <= '0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            out_q   <= out_d;
            oeb_q   <= oeb_d;
            pu_q    <= pu_d;
            pd_q    <= pd_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign gpio     = out_q;
    assign gpio_oeb = oeb_q;
    assign gpio_pu  = pu_q;
    assign gpio_pd  = pd_q;

endmodule

// File: tb/tb_gpio_bank_wb.sv
// Directed, table-driven bench for gpio_bank_wb (N_GPIO=16); interrupt checks
// follow whether GPIO_BANK_IRQ_EN is defined for the build.
module tb_gpio_bank_wb;

    localparam logic [31:0] B = 32'h2100_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dat_i, adr_i, dat_o;
    logic [3:0]  sel_i;
    logic        cyc, stb, we_i, ack, irq;
    logic [15:0] pad, gpio, oeb, pu, pd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_bank_wb #(.BASE_ADR(B), .N_GPIO(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb_dat_i    (dat_i),
        .wb_adr_i    (adr_i),
        .wb_sel_i    (sel_i),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we_i),
        .wb_dat_o    (dat_o),
        .wb_ack_o    (ack),
        .gpio_in_pad (pad),
        .gpio        (gpio),
        .gpio_oeb    (oeb),
        .gpio_pu     (pu),
        .gpio_pd     (pd),
        .irq         (irq)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic [31:0] exp_rd;
        logic        chk_gpio;
        logic [15:0] exp_gpio;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one access from a negedge; returns #1 after the ack edge with the bus released.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic acked, output logic [31:0] rd,
                       output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        acked = 1'b0; rd = '0; lat = 0;
        for (int i = 1; i <= 4 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                lat = i;
                rd = dat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        a;
        logic [31:0] r;
        int          l;

        vt[0]  = '{1'b0, B + 32'h08, 32'h0,         4'hF, 1'b1, 32'h0000_FFFF, 1'b0, 16'h0};
        vt[1]  = '{1'b0, B + 32'h04, 32'h0,         4'hF, 1'b1, 32'h0,         1'b0, 16'h0};
        vt[2]  = '{1'b0, B + 32'h0C, 32'h0,         4'hF, 1'b1, 32'h0,         1'b0, 16'h0};
        vt[3]  = '{1'b0, B + 32'h10, 32'h0,         4'hF, 1'b1, 32'h0,         1'b0, 16'h0};
        vt[4]  = '{1'b1, B + 32'h04, 32'h0000_A5A5, 4'h1, 1'b1, 32'h0,         1'b1, 16'h00A5};
        vt[5]  = '{1'b0, B + 32'h04, 32'h0,         4'hF, 1'b1, 32'h0000_00A5, 1'b0, 16'h0};
        vt[6]  = '{1'b1, B + 32'h04, 32'hFFFF_1234, 4'hF, 1'b1, 32'h0,         1'b1, 16'h1234};
        vt[7]  = '{1'b0, B + 32'h04, 32'h0,         4'hF, 1'b1, 32'h0000_1234, 1'b0, 16'h0};
        vt[8]  = '{1'b1, B + 32'h04, 32'h0000_5600, 4'h2, 1'b1, 32'h0,         1'b1, 16'h5634};
        vt[9]  = '{1'b0, B + 32'h04, 32'h0,         4'hF, 1'b1, 32'h0000_5634, 1'b0, 16'h0};
        vt[10] = '{1'b1, B + 32'h08, 32'h0,         4'h1, 1'b1, 32'h0,         1'b0, 16'h0};
        vt[11] = '{1'b0, B + 32'h08, 32'h0,         4'hF, 1'b1, 32'h0000_FF00, 1'b0, 16'h0};
        vt[12] = '{1'b1, B + 32'h0C, 32'h0000_00F0, 4'h3, 1'b1, 32'h0,         1'b0, 16'h0};
        vt[13] = '{1'b1, B + 32'h10, 32'h0000_0F0F, 4'h3, 1'b1, 32'h0,         1'b0, 16'h0};
        vt[14] = '{1'b0, B + 32'h40, 32'h0,         4'hF, 1'b1, 32'h0,         1'b0, 16'h0};
        vt[15] = '{1'b1, B + 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         1'b0, 16'h0};
        vt[16] = '{1'b1, B + 32'h104, 32'h0000_FFFF, 4'hF, 1'b0, 32'h0,        1'b0, 16'h0};
        vt[17] = '{1'b0, B + 32'h00, 32'h0,         4'hF, 1'b1, 32'h0000_3C00, 1'b0, 16'h0};
        vt[18] = '{1'b0, B + 32'h0C, 32'h0,         4'hF, 1'b1, 32'h0000_00F0, 1'b0, 16'h0};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        dat_i = '0; adr_i = '0; sel_i = '0; pad = 16'h3C00;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_gpio", {16'h0, gpio}, 32'h0);
        chk("rst_oeb",  {16'h0, oeb},  32'hFFFF);
        chk("rst_pu",   {16'h0, pu},   32'h0);
        chk("rst_pd",   {16'h0, pd},   32'h0);
        chk("rst_ack",  {31'h0, ack},  32'h0);
        chk("rst_dat",  dat_o,         32'h0);
        chk("rst_irq",  {31'h0, irq},  32'h0);

        for (int i = 0; i < 19; i++) begin
            bus(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, a, r, l);
            chk($sformatf("v%0d_ack", i), {31'h0, a}, {31'h0, vt[i].exp_ack});
            if (vt[i].exp_ack) begin
                chk($sformatf("v%0d_lat", i), l, 32'd1);
                if (!vt[i].we) chk($sformatf("v%0d_rd", i), r, vt[i].exp_rd);
            end
            if (vt[i].chk_gpio) chk($sformatf("v%0d_gpio", i), {16'h0, gpio}, {16'h0, vt[i].exp_gpio});
            @(posedge clk); #1;
            chk($sformatf("v%0d_ackw", i), {31'h0, ack}, 32'h0);
        end
        chk("out_gpio", {16'h0, gpio}, 32'h5634);
        chk("out_oeb",  {16'h0, oeb},  32'hFF00);
        chk("out_pu",   {16'h0, pu},   32'h00F0);
        chk("out_pd",   {16'h0, pd},   32'h0F0F);

        // Held strobe: the ack-cycle block yields acks every other edge.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = B + 32'h04; sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_%0d", i), {31'h0, ack}, {31'h0, (i % 2 == 0)});
        end
        cyc = 1'b0; stb = 1'b0;

`ifdef GPIO_BANK_IRQ_EN
        bus(1'b1, B + 32'h14, 32'h1, 4'h3, a, r, l);
        @(negedge clk); pad[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rise_irq_e%0d", i), {31'h0, irq}, {31'h0, (i == 3)});
        end
        bus(1'b0, B + 32'h1C, 32'h0, 4'hF, a, r, l);
        chk("stat_rise", r, 32'h1);
        bus(1'b1, B + 32'h1C, 32'h1, 4'h1, a, r, l);
        chk("w1c_ack", {31'h0, a}, 32'h1);
        chk("w1c_irq", {31'h0, irq}, 32'h0);

        bus(1'b1, B + 32'h18, 32'h2, 4'hF, a, r, l);
        @(negedge clk); pad[1] = 1'b1;
        repeat (4) @(posedge clk);
        bus(1'b0, B + 32'h1C, 32'h0, 4'hF, a, r, l);
        chk("stat_norise", r, 32'h0);
        @(negedge clk); pad[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = B + 32'h1C; dat_i = 32'h2; sel_i = 4'h1;
        @(posedge clk); #1;
        chk("coinc_ack", {31'h0, ack}, 32'h1);
        chk("coinc_irq", {31'h0, irq}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        bus(1'b0, B + 32'h1C, 32'h0, 4'hF, a, r, l);
        chk("stat_coinc", r, 32'h2);
        bus(1'b1, B + 32'h1C, 32'h2, 4'h0, a, r, l);
        bus(1'b0, B + 32'h1C, 32'h0, 4'hF, a, r, l);
        chk("stat_nosel", r, 32'h2);
        bus(1'b1, B + 32'h1C, 32'h2, 4'h1, a, r, l);
        chk("clr2_irq", {31'h0, irq}, 32'h0);
        bus(1'b0, B + 32'h1C, 32'h0, 4'hF, a, r, l);
        chk("stat_clr2", r, 32'h0);
`else
        bus(1'b1, B + 32'h14, 32'hFFFF, 4'hF, a, r, l);
        chk("noirq_wack", {31'h0, a}, 32'h1);
        bus(1'b0, B + 32'h14, 32'h0, 4'hF, a, r, l);
        chk("noirq_rise", r, 32'h0);
        @(negedge clk); pad[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("noirq_irq", {31'h0, irq}, 32'h0);
        bus(1'b0, B + 32'h1C, 32'h0, 4'hF, a, r, l);
        chk("noirq_stat", r, 32'h0);
`endif

        // Reset inside the ack cycle clears ack and read data without an edge.
        bus(1'b0, B + 32'h08, 32'h0, 4'hF, a, r, l);
        chk("pre_rst_rd", r, 32'hFF00);
        rst = 1'b1;
        #1;
        chk("arst_ack", {31'h0, ack}, 32'h0);
        chk("arst_dat", dat_o, 32'h0);
        chk("arst_oeb", {16'h0, oeb}, 32'hFFFF);
        chk("arst_gpio", {16'h0, gpio}, 32'h0);
        @(negedge clk); rst = 1'b0;

        bus(1'b1, B + 32'h04, 32'h0000_00FF, 4'h1, a, r, l);
        chk("set_gpio", {16'h0, gpio}, 32'h00FF);
        // Reset while a write strobe is pending: write lost, outputs reset at once.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = B + 32'h04; dat_i = 32'h1111; sel_i = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("mid_ack",  {31'h0, ack},  32'h0);
        chk("mid_gpio", {16'h0, gpio}, 32'h0);
        chk("mid_oeb",  {16'h0, oeb},  32'hFFFF);
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0; rst = 1'b0;
        bus(1'b0, B + 32'h04, 32'h0, 4'hF, a, r, l);
        chk("lost_wr", r, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
